mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the memory-mapped `Memory` block (RAM, button and LED I/O). It lets two requesters share the single memory port: the CPU data port on port 0 and the UART program loader / debug master on port 1. It arbitrates between them, latches the winning request, drives one memory cycle, waits out the read latency, and returns read data with a one-cycle acknowledge.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the Memory block.
// Port 0 is the CPU data port, port 1 the loader/debug master.
module mem_arbiter #(
  parameter int READ_LAT   = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic [15:0] mem_address,
  output logic        mem_load,
  output logic [15:0] mem_in,
  input  logic [15:0] mem_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        win_q, win_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        gnt0_q, gnt1_q;
  logic        ack0_q, ack1_q;
  logic        load_q;
  logic        pick1;

  // Port 1 wins when alone, or on a round-robin tie when port 0 was served last.
  always_comb begin
    pick1 = req1 & (~req0 | (~FIXED_PRIO & ~last_q));
  end

  // Next-state logic: sequence one latched transaction through the memory.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          win_d   = pick1;
          we_d    = pick1 ? we1 : we0;
          addr_d  = pick1 ? addr1 : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_out;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt0_q  <= (state_d != S_IDLE) & ~win_d;
      gnt1_q  <= (state_d != S_IDLE) & win_d;
      ack0_q  <= (state_d == S_DONE) & ~win_d;
      ack1_q  <= (state_d == S_DONE) & win_d;
      load_q  <= (state_d == S_ISSUE) & we_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata       = rdata_q;
  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign mem_load    = load_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two builds (RR/lat1, fixed-prio/lat3)
// against a transaction-level model with a small memory.
module tb_mem_arbiter;

  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  bit done [2];

  task automatic chk(input string nm, input int inst, input int cyc,
                     input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s inst%0d cyc%0d: got %h expected %h",
                  nm, inst, cyc, act, exp);
  endtask

  function automatic int idx(input logic [15:0] a);
    return int'({a[13], a[4:0]});
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = (g == 0) ? 1 : 3;
    localparam bit P = (g == 0) ? 1'b0 : 1'b1;
    localparam int S = 11 + 3 * L;

    logic        rst, init_mem;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1, mem_load;
    logic [15:0] rdata, mem_address, mem_in, mem_out;

    mem_arbiter #(.READ_LAT(L), .FIXED_PRIO(P)) dut (
      .clk(clk), .reset(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata(rdata), .mem_address(mem_address),
      .mem_load(mem_load), .mem_in(mem_in), .mem_out(mem_out)
    );

    // Memory stand-in: synchronous read, extra pipe stages up to READ_LAT.
    logic [15:0] ram  [64];
    logic [15:0] pipe [4];
    always @(posedge clk) begin
      pipe[0] <= ram[idx(mem_address)];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      if (init_mem) begin
        for (int i = 0; i < 64; i++) ram[i] <= 16'd0;
        ram[5] <= 16'hBEEF;
      end else if (mem_load) begin
        ram[idx(mem_address)] <= mem_in;
      end
    end
    assign mem_out = pipe[L-1];

    logic [15:0] sh [64];
    bit          m_busy, m_win, m_last, m_we;
    int          m_k;
    logic [15:0] m_addr, m_din, m_rd, m_prd;
    logic [4:0]  e_ctl;
    bit          pend [2];
    int          cool [2];

    initial begin : run
      logic [4:0] dctl;
      bit         w;
      for (int i = 0; i < 64; i++) sh[i] = 16'd0;
      sh[5] = 16'hBEEF;
      m_busy = 0; m_win = 0; m_last = 1; m_we = 0; m_k = 0;
      m_addr = 0; m_din = 0; m_rd = 0; m_prd = 0; e_ctl = 0;
      pend[0] = 0; pend[1] = 0; cool[0] = 0; cool[1] = 0;
      rst = 1; init_mem = 1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      for (int n = -3; n < NCYC; n++) begin
        @(negedge clk);
        dctl = {gnt0, gnt1, ack0, ack1, mem_load};
        chk("ctl", g, n, 16'(dctl), 16'(e_ctl));
        chk("rdata", g, n, rdata, m_rd);
        if (m_busy && m_k <= L + 1) begin
          chk("addr", g, n, mem_address, m_addr);
          chk("din", g, n, mem_in, m_din);
        end
        if (n == -1) begin
          chk("rst_ctl", g, n, 16'(dctl), 16'd0);
          chk("rst_addr", g, n, mem_address, 16'd0);
          chk("rst_rdata", g, n, rdata, 16'd0);
        end
        if (n == 2 + L) begin
          chk("rd_ack", g, n, 16'({ack0, ack1}), 16'b10);
          chk("rd_data", g, n, rdata, 16'hBEEF);
        end
        if (n == 4 + L) begin
          chk("wr_issue", g, n, 16'({mem_load, gnt1}), 16'b11);
          chk("wr_addr", g, n, mem_address, 16'h0010);
        end
        if (n == 8 + 3 * L) begin
          chk("rd2_ack", g, n, 16'(ack0), 16'd1);
          chk("rd2_data", g, n, rdata, 16'h1234);
        end
        if (n == S + 3) begin
          chk("abort_ctl", g, n, 16'(dctl), 16'd0);
          chk("abort_rd", g, n, rdata, 16'd0);
        end

        rst = (n < 0);
        init_mem = (n == -3);
        for (int p = 0; p < 2; p++) begin
          if (e_ctl[2-p]) begin
            pend[p] = 0; cool[p] = 1;
            if (p == 0) req0 = 0; else req1 = 0;
          end else if (cool[p] > 0) begin
            cool[p]--;
          end else if (n > S + 3) begin
            if (pend[p] && m_busy && m_win == p && $urandom_range(7) == 0) begin
              pend[p] = 0;
              if (p == 0) req0 = 0; else req1 = 0;
            end else if (!pend[p] && !(m_busy && m_win == p)
                         && $urandom_range(3) == 0) begin
              pend[p] = 1;
              if (p == 0) begin
                req0 = 1; we0 = 1'($urandom_range(1));
                addr0 = ($urandom_range(7) == 0) ? 16'h2001
                                                 : 16'($urandom_range(15));
                wdata0 = 16'($urandom);
              end else begin
                req1 = 1; we1 = 1'($urandom_range(1));
                addr1 = ($urandom_range(7) == 0) ? 16'h2001
                                                 : 16'($urandom_range(15));
                wdata1 = 16'($urandom);
              end
            end
          end
        end
        if (n == 0) begin
          req0 = 1; we0 = 0; addr0 = 16'h0005; pend[0] = 1;
          req1 = 1; we1 = 1; addr1 = 16'h0010; wdata1 = 16'h1234;
          pend[1] = 1;
        end
        if (n == 7 + L) begin
          req0 = 1; we0 = 0; addr0 = 16'h0010; pend[0] = 1;
        end
        if (n == S) begin
          req0 = 1; we0 = 0; addr0 = 16'h0005; pend[0] = 1;
        end
        if (n == S + 2) begin
          rst = 1; req0 = 0; pend[0] = 0;
        end
        if (n > S + 3 && $urandom_range(199) == 0) rst = 1;

        if (m_busy && m_k == 1) begin
          m_prd = sh[idx(m_addr)];
          if (m_we) sh[idx(m_addr)] = m_din;
        end
        if (rst) begin
          m_busy = 0; m_last = 1; m_rd = 0;
        end else if (!m_busy) begin
          if (req0 || req1) begin
            if (req0 && req1) w = P ? 1'b0 : !m_last;
            else w = req1;
            m_win  = w;
            m_we   = w ? we1 : we0;
            m_addr = w ? addr1 : addr0;
            m_din  = w ? wdata1 : wdata0;
            m_busy = 1; m_k = 1;
          end
        end else begin
          if (m_k == L + 1) m_rd = m_prd;
          if (m_k == L + 2) begin
            m_busy = 0; m_last = m_win;
          end else begin
            m_k++;
          end
        end
        e_ctl = {m_busy && !m_win, m_busy && m_win,
                 m_busy && !m_win && m_k == L + 2,
                 m_busy && m_win && m_k == L + 2,
                 m_busy && m_k == 1 && m_we};
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < NCYC + 100 && !(done[0] && done[1]); i++)
      @(posedge clk);
    if (!(done[0] && done[1])) begin
      total++;
      $display("FAIL timeout: done %0d%0d required 11", done[0], done[1]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
